// File: rtl/data_mem_resp.sv
// Word-addressed 32-bit data memory with fixed wait states, error detection and a one-cycle completion pulse.
// Latency: memReady rises WAIT_CYCLES+1 cycles after acceptance; one request in flight, no new acceptance until after RESP.
module data_mem_resp #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWrite,
  input  logic [31:0] memAddr,
  input  logic [31:0] memwriteData,
  output logic [31:0] memreadData,
  output logic        memReady,
  output logic        memErr
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                 write;
    logic                 err;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          wdat;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        held;
  req_t        in_req;
  req_t        cur;
  logic        enter_resp;
  logic [31:0] mem [2**ADDR_BITS];

  always_comb begin
    in_req.write = memWrite;
    in_req.err   = (memAddr[1:0] != 2'b00) || ((memAddr >> (ADDR_BITS + 2)) != 32'd0);
    in_req.idx   = memAddr[ADDR_BITS+1:2];
    in_req.wdat  = memwriteData;
  end

  // With zero wait states the access completes straight from the live inputs.
  assign cur        = (state == IDLE) ? in_req : held;
  assign enter_resp = ((state == IDLE) && memCe && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur.write && !cur.err)
      mem[cur.idx] <= cur.wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      memreadData <= 32'h0000_0000;
      memReady    <= 1'b0;
      memErr      <= 1'b0;
    end else begin
      memReady <= 1'b0;
      memErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (memCe) begin
            held <= in_req;
            if (WAIT_CYCLES != 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT:    if (cnt != 4'd0) cnt <= cnt - 4'd1;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Completion overrides the state chosen above.
      if (enter_resp) begin
        state    <= RESP;
        memReady <= 1'b1;
        memErr   <= cur.err;
        if (!cur.write)
          memreadData <= cur.err ? 32'h0000_0000 : mem[cur.idx];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: expected completions queued at request time, checked on memReady.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        memCe;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memwriteData;
  logic [31:0] memreadData;
  logic        memReady;
  logic        memErr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  data_mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .memCe        (memCe),
    .memWrite     (memWrite),
    .memAddr      (memAddr),
    .memwriteData (memwriteData),
    .memreadData  (memreadData),
    .memReady     (memReady),
    .memErr       (memErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic w, input logic [31:0] a, input logic [31:0] d);
    memCe        = ce;
    memWrite     = w;
    memAddr      = a;
    memwriteData = d;
  endtask

  // Waits (bounded) for the completion pulse, checks latency in negedges, then pops and compares.
  task automatic wait_resp(input string tag, input int lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!memReady && n < 12);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_sb_depth_ok"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (memReady) begin
        chk({tag, "_err"}, {31'd0, memErr}, {31'd0, e.err});
        chk({tag, "_rdata"}, memreadData, e.rd);
      end
    end
  endtask

  // Issues one request from a negedge; scrambles inputs during WAIT to prove they are ignored.
  task automatic req(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic ee, input logic [31:0] erd);
    drive(1'b1, w, a, d);
    sb.push_back(exp_t'{err: ee, rd: erd});
    @(posedge clk);
    #1 drive(1'b0, ~w, 32'h0000_0020, 32'hFFFF_FFFF);
    wait_resp(tag, 3);
    @(negedge clk);
    chk({tag, "_pulse_end"}, {31'd0, memReady}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, memReady}, 32'd0);
    chk("rst_err", {31'd0, memErr}, 32'd0);
    chk("rst_rdata", memreadData, 32'h0000_0000);
    repeat (2) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, memReady}, 32'd0);
    end

    req("st_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
    req("ld_10", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
    req("st_misaligned", 1'b1, 32'h0000_0011, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
    req("ld_10_again", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF);
    req("ld_oor", 1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0000_0000);
    req("st_20", 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 32'h0000_0000);
    req("ld_20", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D);

    // Store aborted by reset one edge after acceptance.
    drive(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (memReady) pulses++;
    end
    chk("abort_no_ready", pulses, 32'd0);
    chk("abort_rdata_cleared", memreadData, 32'h0000_0000);
    req("ld_20_after_abort", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0BAD_F00D);

    // memCe held high throughout; address moves to 0x20 during WAIT.
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    sb.push_back(exp_t'{err: 1'b0, rd: 32'hDEAD_BEEF});
    sb.push_back(exp_t'{err: 1'b0, rd: 32'h0BAD_F00D});
    @(posedge clk);
    #1 memAddr = 32'h0000_0020;
    wait_resp("hold_first", 3);
    wait_resp("hold_second", 4);
    memCe = 1'b0;
    @(negedge clk);
    chk("hold_pulse_end", {31'd0, memReady}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width (memory depth 2^ADDR_BITS 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, access wait states; legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port memCe  input  1  request valid from memory-stage initiator.
REQ-006 SHALL have port memWrite  input  1  1 = store, 0 = load; sampled only with memCe.
REQ-007 SHALL have port memAddr  input  32  byte address.
REQ-008 SHALL have port memwriteData  input  32  store data.
REQ-009 SHALL have port memreadData  output  32  registered load data.
REQ-010 SHALL have port memReady  output  1  one-cycle completion pulse.
REQ-011 SHALL have port memErr  output  1  one-cycle error pulse, coincident with memReady.

Function
REQ-012 SHALL hold 2^ADDR_BITS x 32 storage, indexed by memAddr[ADDR_BITS+1:2].
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE with memCe=1 at edge E SHALL capture memAddr, memwriteData, memWrite and advance: to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to RESP.
REQ-015 WAIT SHALL decrement counter each edge and move to RESP on the edge where counter==0.
REQ-016 memReady SHALL be high exactly during the RESP cycle, i.e. WAIT_CYCLES+1 cycles after acceptance edge E.
REQ-017 RESP SHALL return to IDLE unconditionally on the next edge; memCe during the RESP cycle SHALL be ignored; the earliest next acceptance is the cycle after RESP.
REQ-018 Inputs SHALL be ignored in WAIT and RESP; changes there SHALL NOT affect the in-flight access.
REQ-019 A valid store SHALL update the addressed word on the edge entering RESP; memreadData SHALL be unchanged by stores.
REQ-020 A valid load SHALL load memreadData on the edge entering RESP; memreadData SHALL hold until the next completing load or reset.
REQ-021 A request SHALL be erroneous if memAddr[1:0]!=0 or memAddr[31:ADDR_BITS+2]!=0.
REQ-022 An erroneous request SHALL complete with normal timing, assert memErr with memReady, perform no store, and, if a load, set memreadData to 0.
REQ-023 A load following a store to the same word SHALL return the stored value.
REQ-024 memCe=0 in IDLE SHALL keep the FSM in IDLE with memReady=0.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, counter=0, memreadData=0x00000000, memReady=0, memErr=0.
REQ-026 Reset SHALL NOT clear storage contents.
REQ-027 Reset during WAIT SHALL abort the access: no store performed, no memReady pulse.
REQ-028 rst SHALL take priority over memCe in the same cycle.

Verification (WAIT_CYCLES=2, ADDR_BITS=10)
REQ-029 Reset 1 cycle, then idle -> memReady=0, memErr=0, memreadData=0x00000000.
REQ-030 Store 0xDEADBEEF to 0x00000010 accepted at edge E -> memReady high in cycle E+3 only; then load 0x00000010 -> memreadData=0xDEADBEEF with its memReady pulse.
REQ-031 Store 0x12345678 to 0x00000011 (misaligned) -> memErr=memReady=1 at E+3; load 0x00000010 still returns 0xDEADBEEF.
REQ-032 Load 0x00001000 (out of range) -> memErr=1, memreadData=0x00000000 at completion.
REQ-033 Store 0xCAFEF00D to 0x00000020, assert rst in cycle E+1 -> no memReady; later load 0x00000020 returns prior contents, not 0xCAFEF00D.
REQ-034 Load accepted, memAddr changed to 0x00000020 during WAIT -> returns word at originally captured address; memCe held high through RESP -> no second acceptance until the cycle after RESP.
